// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - EX-stage M-extension op/result bundle between pipeline and mul/div unit
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start_in;
  logic [2:0]      funct3_in;
  logic [XLEN-1:0] op_a_in;
  logic [XLEN-1:0] op_b_in;
  logic [4:0]      rd_in;
  logic            flush;
  logic            stall_out;
  logic            done_out;
  logic [XLEN-1:0] result_out;
  logic [4:0]      rd_out;

  modport master (
    output start_in, funct3_in, op_a_in, op_b_in, rd_in, flush,
    input  stall_out, done_out, result_out, rd_out
  );

  modport slave (
    input  start_in, funct3_in, op_a_in, op_b_in, rd_in, flush,
    output stall_out, done_out, result_out, rd_out
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide, one result bit per cycle
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic              clk,
  input logic              reset,
  ex_muldiv_unit_if.slave  bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] hi_q, lo_q, opnd_q, result_q;
  logic            sign_a_q, sign_b_q;

  logic            sa_en, sb_en, sa, sb, div_zero, div_ovf, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  always_comb begin
    sa_en    = (bus.funct3_in == 3'b001) | (bus.funct3_in == 3'b010) |
               (bus.funct3_in == 3'b100) | (bus.funct3_in == 3'b110);
    sb_en    = (bus.funct3_in == 3'b001) | (bus.funct3_in == 3'b100) |
               (bus.funct3_in == 3'b110);
    sa       = sa_en & bus.op_a_in[XLEN-1];
    sb       = sb_en & bus.op_b_in[XLEN-1];
    mag_a    = sa ? -bus.op_a_in : bus.op_a_in;
    mag_b    = sb ? -bus.op_b_in : bus.op_b_in;
    div_zero = bus.funct3_in[2] & (bus.op_b_in == '0);
    div_ovf  = bus.funct3_in[2] & ~bus.funct3_in[0] &
               (bus.op_a_in == {1'b1, {(XLEN-1){1'b0}}}) & (bus.op_b_in == '1);
    fast     = div_zero | div_ovf;
    if (div_zero) fast_res = bus.funct3_in[1] ? bus.op_a_in : '1;
    else          fast_res = bus.funct3_in[1] ? '0 : bus.op_a_in;
  end

  // Multiply shifts {hi,lo} right adding the multiplicand; divide shifts left restoring into hi.
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [XLEN-1:0] hi_nx, lo_nx;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (f3_q[2]) begin
      if (!div_diff[XLEN]) begin
        hi_nx = div_diff[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nx = div_shift[XLEN-1:0];
        lo_nx = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nx = mul_sum[XLEN:1];
      lo_nx = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result_d;

  always_comb begin
    prod     = {hi_nx, lo_nx};
    prod_fix = (sign_a_q ^ sign_b_q) ? -prod : prod;
    quo_fix  = (sign_a_q ^ sign_b_q) ? -lo_nx : lo_nx;
    rem_fix  = sign_a_q ? -hi_nx : hi_nx;
    if (f3_q[2])                result_d = f3_q[1] ? rem_fix : quo_fix;
    else if (f3_q[1:0] == 2'b00) result_d = prod_fix[XLEN-1:0];
    else                        result_d = prod_fix[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_in && !bus.flush) begin
            f3_q     <= bus.funct3_in;
            rd_q     <= bus.rd_in;
            sign_a_q <= sa;
            sign_b_q <= sb;
            hi_q     <= '0;
            lo_q     <= bus.funct3_in[2] ? mag_a : mag_b;
            opnd_q   <= bus.funct3_in[2] ? mag_b : mag_a;
            cnt_q    <= '0;
            if (fast) begin
              result_q <= fast_res;
              state_q  <= DONE;
            end else begin
              state_q  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            hi_q  <= hi_nx;
            lo_q  <= lo_nx;
            cnt_q <= cnt_q + CW'(1);
            if (cnt_q == CW'(XLEN-1)) begin
              result_q <= result_d;
              state_q  <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.stall_out  = ((state_q == IDLE) & bus.start_in & ~bus.flush) | (state_q == BUSY);
  assign bus.done_out   = (state_q == DONE) & ~bus.flush;
  assign bus.result_out = result_q;
  assign bus.rd_out     = rd_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized self-checking bench for ex_muldiv_unit against an arithmetic model
module tb_ex_muldiv_unit;
  logic clk;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  ex_muldiv_unit_if #(.XLEN(32)) bus ();
  ex_muldiv_unit #(.XLEN(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    int ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    ia = $signed(a);
    ib = $signed(b);
    case (f3)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
    int done_cyc, n_done, n_stall, lat;
    logic [31:0] res;
    logic [4:0]  rdo;
    done_cyc = -1; n_done = 0; n_stall = 0; res = 'x; rdo = 'x;
    lat = is_fast(f3, a, b) ? 1 : 33;
    @(negedge clk);
    bus.start_in = 1'b1; bus.funct3_in = f3; bus.op_a_in = a; bus.op_b_in = b; bus.rd_in = rd;
    #1;
    if (bus.stall_out) n_stall++;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      bus.op_a_in  = $urandom;
      bus.op_b_in  = $urandom;
      #1;
      if (bus.stall_out) n_stall++;
      if (bus.done_out) begin
        n_done++;
        done_cyc = c;
        res = bus.result_out;
        rdo = bus.rd_out;
      end
    end
    check({tag, " result"}, res, exp);
    check({tag, " rd"}, 32'(rdo), 32'(rd));
    check({tag, " done_cycle"}, 32'(done_cyc), 32'(lat));
    check({tag, " done_pulses"}, 32'(n_done), 32'd1);
    check({tag, " stall_cycles"}, 32'(n_stall), 32'(lat));
  endtask

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.start_in = 1'b0; bus.funct3_in = '0; bus.op_a_in = '0; bus.op_b_in = '0;
    bus.rd_in = '0; bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset stall", 32'(bus.stall_out), 32'd0);
    check("reset done", 32'(bus.done_out), 32'd0);
    check("reset result", bus.result_out, 32'd0);
    check("reset rd", 32'(bus.rd_out), 32'd0);
    reset = 1'b0;

    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd11, 32'hFFFF_FFEB);
    run_op("mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000);
    run_op("mulhu", 3'd3, 32'h8000_0000, 32'h8000_0000, 5'd2, 32'h4000_0000);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFF);
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd4, 32'hFFFF_FFFD);
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFF);
    run_op("divu", 3'd5, 32'd100, 32'd7, 5'd6, 32'd14);
    run_op("remu", 3'd7, 32'd100, 32'd7, 5'd7, 32'd2);
    run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd8, 32'hFFFF_FFFF);
    run_op("rem0", 3'd6, 32'd5, 32'd0, 5'd9, 32'd5);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0);

    // Flush in cycle 10 of a DIV, then MUL 3x4 from cycle 12.
    @(negedge clk);
    bus.start_in = 1'b1; bus.funct3_in = 3'd4; bus.op_a_in = 32'd1000; bus.op_b_in = 32'd3; bus.rd_in = 5'd13;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      bus.start_in = 1'b0;
      bus.flush = (c == 10);
      #1;
      if (c == 10) check("flush busy done", 32'(bus.done_out), 32'd0);
      if (c == 11) check("flush stall drop", 32'(bus.stall_out), 32'd0);
      if (c == 11) check("flush no done", 32'(bus.done_out), 32'd0);
    end
    run_op("mul_after_flush", 3'd0, 32'd3, 32'd4, 5'd14, 32'd12);

    // Flush together with start in IDLE.
    @(negedge clk);
    bus.start_in = 1'b1; bus.flush = 1'b1; bus.funct3_in = 3'd0; bus.op_a_in = 32'd5; bus.op_b_in = 32'd5;
    #1;
    check("flush_start stall", 32'(bus.stall_out), 32'd0);
    @(negedge clk);
    bus.start_in = 1'b0; bus.flush = 1'b0;
    #1;
    check("flush_start stall next", 32'(bus.stall_out), 32'd0);
    check("flush_start done", 32'(bus.done_out), 32'd0);

    // Flush arriving in DONE of a fast case.
    @(negedge clk);
    bus.start_in = 1'b1; bus.funct3_in = 3'd5; bus.op_a_in = 32'd5; bus.op_b_in = 32'd0;
    @(negedge clk);
    bus.start_in = 1'b0; bus.flush = 1'b1;
    #1;
    check("flush_done done", 32'(bus.done_out), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("flush_done idle", 32'(bus.stall_out), 32'd0);

    // Asynchronous reset between clock edges during BUSY.
    @(negedge clk);
    bus.start_in = 1'b1; bus.funct3_in = 3'd0; bus.op_a_in = 32'd9; bus.op_b_in = 32'd9; bus.rd_in = 5'd15;
    @(negedge clk);
    bus.start_in = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset stall", 32'(bus.stall_out), 32'd0);
    check("areset done", 32'(bus.done_out), 32'd0);
    check("areset result", bus.result_out, 32'd0);
    check("areset rd", 32'(bus.rd_out), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run_op("mul_after_reset", 3'd0, 32'd6, 32'd7, 5'd16, 32'd42);

    for (int i = 0; i < 30; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 255));
        3: b = -32'($urandom_range(1, 255));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, 5'($urandom), model(f3, a, b));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
